// File: rtl/snl_pkg.sv
// Shared types and defaults for the snakes-and-ladders engine: state encoding,
// default board size and the default snake/ladder table.
package snl_pkg;

  localparam int unsigned DEF_BOARD_SIZE = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ROLL = 3'd1,
    ST_MOVE      = 3'd2,
    ST_JUMP      = 3'd3,
    ST_CHECK     = 3'd4,
    ST_WIN       = 3'd5
  } state_e;

  // Ladders climb, snakes fall; any other square maps to itself.
  function automatic int unsigned default_jump(input int unsigned sq);
    case (sq)
      32'd3:   return 32'd20;
      32'd11:  return 32'd28;
      32'd40:  return 32'd58;
      32'd27:  return 32'd5;
      32'd45:  return 32'd25;
      32'd62:  return 32'd34;
      default: return sq;
    endcase
  endfunction

endpackage

// File: rtl/snl_game_engine_if.sv
// Game-control handshake: start pulse, dice offer/accept and illegal-dice flag.
interface snl_game_engine_if;
  logic       start;
  logic       dice_valid;
  logic [2:0] dice;
  logic       dice_ready;
  logic       dice_err;

  modport master (output start, dice_valid, dice, input dice_ready, dice_err);
  modport slave  (input start, dice_valid, dice, output dice_ready, dice_err);
endinterface

// File: rtl/snl_jump_map.sv
// Combinational square -> destination lookup for snakes and ladders.
module snl_jump_map
  import snl_pkg::*;
#(
  parameter int unsigned BOARD_SIZE = DEF_BOARD_SIZE
) (
  input  logic [$clog2(BOARD_SIZE)-1:0] i_sq,
  output logic [$clog2(BOARD_SIZE)-1:0] o_dst
);
  localparam int unsigned POS_W = $clog2(BOARD_SIZE);

  int unsigned w_dst;

  // Table entries that fall off a smaller board degrade to identity.
  always_comb begin
    w_dst = default_jump(32'(i_sq));
    o_dst = (w_dst < BOARD_SIZE) ? POS_W'(w_dst) : i_sq;
  end
endmodule

// File: rtl/snl_game_engine.sv
// Snakes-and-ladders turn engine. Define SNL_BOUNCE_BACK_EN to bounce overshooting
// rolls back from the goal; otherwise an overshooting roll leaves the player in place.
module snl_game_engine
  import snl_pkg::*;
#(
  parameter  int unsigned NUM_PLAYERS = 2,
  parameter  int unsigned BOARD_SIZE  = DEF_BOARD_SIZE,
  localparam int unsigned POS_W       = $clog2(BOARD_SIZE),
  localparam int unsigned PL_W        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  snl_game_engine_if.slave             bus,
  output logic [PL_W-1:0]              cur_player,
  output logic [POS_W-1:0]             pos,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_all,
  output logic [2:0]                   state,
  output logic [PL_W-1:0]              winner
);
  localparam logic [POS_W:0]  LAST_SQ = (POS_W+1)'(BOARD_SIZE - 1);
  localparam logic [PL_W-1:0] LAST_PL = PL_W'(NUM_PLAYERS - 1);

  state_e           r_state, w_next;
  logic [POS_W-1:0] r_pos [NUM_PLAYERS];
  logic [PL_W-1:0]  r_cur, r_winner;
  logic [2:0]       r_dice;
  logic             r_dice_err;

  logic             w_ready, w_illegal, w_accept, w_won;
  logic [POS_W-1:0] w_cur_pos, w_moved, w_jump_dst;
  logic [POS_W:0]   w_tent;

  snl_jump_map #(.BOARD_SIZE(BOARD_SIZE)) u_jump (
    .i_sq  (w_cur_pos),
    .o_dst (w_jump_dst)
  );

  assign w_cur_pos = r_pos[r_cur];
  assign w_ready   = (r_state == ST_WAIT_ROLL);
  assign w_illegal = (bus.dice == 3'd0) || (bus.dice == 3'd7);
  assign w_accept  = bus.dice_valid && w_ready && !w_illegal;
  assign w_won     = ({1'b0, w_cur_pos} == LAST_SQ);
  assign w_tent    = {1'b0, w_cur_pos} + (POS_W+1)'(r_dice);

`ifdef SNL_BOUNCE_BACK_EN
  localparam logic [POS_W:0] BOUNCE_REF = (POS_W+1)'(2 * (BOARD_SIZE - 1));
  logic [POS_W:0] w_bounce;
  assign w_bounce = BOUNCE_REF - w_tent;
  assign w_moved  = (w_tent <= LAST_SQ) ? w_tent[POS_W-1:0] : w_bounce[POS_W-1:0];
`else
  assign w_moved  = (w_tent <= LAST_SQ) ? w_tent[POS_W-1:0] : w_cur_pos;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_WIN: if (bus.start) w_next = ST_WAIT_ROLL;
      ST_WAIT_ROLL:    if (w_accept)  w_next = ST_MOVE;
      ST_MOVE:         w_next = ST_JUMP;
      ST_JUMP:         w_next = ST_CHECK;
      ST_CHECK:        w_next = w_won ? ST_WIN : ST_WAIT_ROLL;
      default:         w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < NUM_PLAYERS; k++) r_pos[k] <= '0;
      r_cur      <= '0;
      r_winner   <= '0;
      r_dice     <= '0;
      r_dice_err <= 1'b0;
    end else begin
      r_dice_err <= w_ready && bus.dice_valid && w_illegal;
      case (r_state)
        ST_IDLE, ST_WIN: begin
          if (bus.start) begin
            for (int unsigned k = 0; k < NUM_PLAYERS; k++) r_pos[k] <= '0;
            r_cur    <= '0;
            r_winner <= '0;
            r_dice   <= '0;
          end
        end
        ST_WAIT_ROLL: if (w_accept) r_dice <= bus.dice;
        ST_MOVE:      r_pos[r_cur] <= w_moved;
        ST_JUMP:      r_pos[r_cur] <= w_jump_dst;
        ST_CHECK: begin
          if (w_won)                r_winner <= r_cur;
          else if (r_dice != 3'd6)  r_cur    <= (r_cur == LAST_PL) ? '0 : r_cur + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pos_all = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) pos_all[k*POS_W +: POS_W] = r_pos[k];
  end

  assign bus.dice_ready = w_ready;
  assign bus.dice_err   = r_dice_err;
  assign cur_player     = r_cur;
  assign pos            = w_cur_pos;
  assign state          = r_state;
  assign winner         = r_winner;
endmodule

// File: tb/tb_snl_game_engine.sv
// Directed bench for snl_game_engine: a scripted two-player game with hand-computed positions.
module tb_snl_game_engine;
  logic        clk = 1'b0;
  logic        rstn;
  logic        cur_player;
  logic [5:0]  pos;
  logic [11:0] pos_all;
  logic [2:0]  state;
  logic        winner;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SNL_BOUNCE_BACK_EN
  localparam int EXP_OVR = 61;
`else
  localparam int EXP_OVR = 60;
`endif

  snl_game_engine_if bus_if ();

  snl_game_engine #(.NUM_PLAYERS(2), .BOARD_SIZE(64)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus_if),
    .cur_player (cur_player),
    .pos        (pos),
    .pos_all    (pos_all),
    .state      (state),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full turn: offer dice, then check positions/turn/state after CHECK resolves.
  task automatic do_turn(input string tag, input logic [2:0] d, input int e0, input int e1,
                         input int ecur, input int estate);
    chk({tag, "/ready"}, 32'(bus_if.dice_ready), 32'd1);
    bus_if.dice_valid = 1'b1;
    bus_if.dice       = d;
    step;
    bus_if.dice_valid = 1'b0;
    step;
    step;
    step;
    chk({tag, "/p0"},    32'(pos_all[5:0]),  e0);
    chk({tag, "/p1"},    32'(pos_all[11:6]), e1);
    chk({tag, "/cur"},   32'(cur_player),    ecur);
    chk({tag, "/state"}, 32'(state),         estate);
  endtask

  initial begin
    rstn              = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.dice_valid = 1'b0;
    bus_if.dice       = 3'd0;
    #12;
    chk("rst/state",  32'(state),            32'd0);
    chk("rst/pos",    32'(pos_all),          32'd0);
    chk("rst/cur",    32'(cur_player),       32'd0);
    chk("rst/winner", 32'(winner),           32'd0);
    chk("rst/err",    32'(bus_if.dice_err),  32'd0);
    chk("rst/ready",  32'(bus_if.dice_ready), 32'd0);

    @(negedge clk);
    rstn         = 1'b1;
    bus_if.start = 1'b1;
    step;
    bus_if.start = 1'b0;
    chk("start/state", 32'(state), 32'd1);

    // First roll traced cycle by cycle: 0+3 -> 3, ladder -> 20, turn to P1.
    chk("r1/ready", 32'(bus_if.dice_ready), 32'd1);
    bus_if.dice_valid = 1'b1;
    bus_if.dice       = 3'd3;
    step;
    bus_if.dice_valid = 1'b0;
    chk("r1/s_move", 32'(state), 32'd2);
    step;
    chk("r1/moved", 32'(pos), 32'd3);
    chk("r1/s_jump", 32'(state), 32'd3);
    step;
    chk("r1/jumped", 32'(pos), 32'd20);
    chk("r1/cur_chk", 32'(cur_player), 32'd0);
    step;
    chk("r1/cur", 32'(cur_player), 32'd1);
    chk("r1/state", 32'(state), 32'd1);
    chk("r1/p0", 32'(pos_all[5:0]), 32'd20);

    do_turn("p1r3",  3'd3, 20, 20, 0, 1);
    do_turn("p0r6a", 3'd6, 26, 20, 0, 1);
    do_turn("p0r6b", 3'd6, 32, 20, 0, 1);
    do_turn("p0r6c", 3'd6, 38, 20, 0, 1);
    do_turn("p0r2",  3'd2, 58, 20, 1, 1);
    do_turn("p1r1",  3'd1, 58, 21, 0, 1);
    do_turn("p0r2b", 3'd2, 60, 21, 1, 1);
    do_turn("p1r5",  3'd5, 60, 26, 0, 1);
    do_turn("ovr",   3'd5, EXP_OVR, 26, 1, 1);
    do_turn("p1s1",  3'd6, EXP_OVR, 32, 1, 1);
    do_turn("p1s2",  3'd6, EXP_OVR, 38, 1, 1);
    do_turn("p1s3",  3'd6, EXP_OVR, 44, 1, 1);
    do_turn("p1s4",  3'd6, EXP_OVR, 50, 1, 1);
    do_turn("p1s5",  3'd6, EXP_OVR, 56, 1, 1);
    do_turn("p1r1b", 3'd1, EXP_OVR, 57, 0, 1);
    do_turn("ovr2",  3'd5, 60, 57, 1, 1);
    do_turn("p1win", 3'd6, 60, 63, 1, 5);
    chk("win/winner", 32'(winner), 32'd1);

    bus_if.dice_valid = 1'b1;
    bus_if.dice       = 3'd3;
    step;
    step;
    bus_if.dice_valid = 1'b0;
    chk("win/hold_state", 32'(state), 32'd5);
    chk("win/hold_p1", 32'(pos_all[11:6]), 32'd63);
    chk("win/ready", 32'(bus_if.dice_ready), 32'd0);
    chk("win/winner2", 32'(winner), 32'd1);

    bus_if.start = 1'b1;
    step;
    bus_if.start = 1'b0;
    chk("new/state", 32'(state), 32'd1);
    chk("new/pos", 32'(pos_all), 32'd0);
    chk("new/cur", 32'(cur_player), 32'd0);

    do_turn("six", 3'd6, 6, 0, 0, 1);
    chk("six/ready", 32'(bus_if.dice_ready), 32'd1);

    bus_if.start = 1'b1;
    step;
    bus_if.start = 1'b0;
    chk("ign/state", 32'(state), 32'd1);
    chk("ign/pos", 32'(pos_all), 32'd6);

    bus_if.dice_valid = 1'b1;
    bus_if.dice       = 3'd0;
    step;
    bus_if.dice_valid = 1'b0;
    chk("d0/err", 32'(bus_if.dice_err), 32'd1);
    chk("d0/state", 32'(state), 32'd1);
    step;
    chk("d0/err_clr", 32'(bus_if.dice_err), 32'd0);
    bus_if.dice_valid = 1'b1;
    bus_if.dice       = 3'd7;
    step;
    bus_if.dice_valid = 1'b0;
    chk("d7/err", 32'(bus_if.dice_err), 32'd1);
    step;
    chk("d7/err_clr", 32'(bus_if.dice_err), 32'd0);
    chk("d7/pos", 32'(pos_all), 32'd6);
    chk("d7/state", 32'(state), 32'd1);

    // Reset mid-turn, between clock edges while in JUMP.
    bus_if.dice_valid = 1'b1;
    bus_if.dice       = 3'd1;
    step;
    bus_if.dice_valid = 1'b0;
    step;
    chk("mid/s_jump", 32'(state), 32'd3);
    chk("mid/moved", 32'(pos), 32'd7);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid/state", 32'(state), 32'd0);
    chk("mid/pos", 32'(pos_all), 32'd0);
    chk("mid/cur", 32'(cur_player), 32'd0);
    bus_if.start = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    step;
    bus_if.start = 1'b0;
    chk("rel/state", 32'(state), 32'd1);
    chk("rel/pos", 32'(pos_all), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/snl_game_engine.md
SNL_GAME_ENGINE -- requirements
Module: snl_game_engine

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players (2..8).
REQ-002 Parameter BOARD_SIZE, default 64, squares numbered 0..BOARD_SIZE-1; square 0 is start, BOARD_SIZE-1 is goal.
REQ-003 Derived POS_W = $clog2(BOARD_SIZE) and PL_W = max(1,$clog2(NUM_PLAYERS)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  pulse; begins a new game from IDLE or WIN.
REQ-007 dice_valid  input  1  dice value offered this cycle.
REQ-008 dice  input  3  roll value; legal 1..6.
REQ-009 dice_ready  output  1  high only in WAIT_ROLL.
REQ-010 cur_player  output  PL_W  index of player whose turn it is.
REQ-011 pos  output  POS_W  current position of cur_player.
REQ-012 pos_all  output  NUM_PLAYERS*POS_W  all positions, player k at bits [k*POS_W +: POS_W].
REQ-013 state  output  3  encoded FSM state.
REQ-014 winner  output  PL_W  winning player index, valid while state==WIN.
REQ-015 dice_err  output  1  one-cycle pulse when an illegal dice value (0 or 7) is offered in WAIT_ROLL.

Function
REQ-016 States: IDLE=0, WAIT_ROLL=1, MOVE=2, JUMP=3, CHECK=4, WIN=5; codes 6,7 unreachable and return to IDLE.
REQ-017 IDLE: start -> all positions 0, cur_player 0, go WAIT_ROLL next edge.
REQ-018 WAIT_ROLL: handshake completes on dice_valid && dice_ready && dice in 1..6; dice latched, go MOVE.
REQ-019 WAIT_ROLL: illegal dice with dice_valid -> dice_err pulse next cycle, stay WAIT_ROLL, no position change.
REQ-020 MOVE: tentative = pos + dice computed at POS_W+1 bits; if tentative <= BOARD_SIZE-1, pos <= tentative; overshoot handled per REQ-031; go JUMP.
REQ-021 JUMP: pos <= jump_map(pos) (identity for non snake/ladder squares); go CHECK.
REQ-022 CHECK: pos==BOARD_SIZE-1 -> winner <= cur_player, go WIN; else if latched dice==6 same player rolls again; else cur_player advances, wrapping NUM_PLAYERS-1 -> 0; go WAIT_ROLL.
REQ-023 Latency: roll accepted at edge N -> move visible after N+1, jump after N+2, turn change/WIN after N+3.
REQ-024 WIN: positions and winner held; dice ignored; start -> new game per REQ-017.
REQ-025 start outside IDLE/WIN is ignored.
REQ-026 Only the current player's position may change; others hold.

Reset
REQ-027 rstn low: state IDLE, all positions 0, cur_player 0, winner 0, dice_err 0, latched dice 0, immediately and independent of clk.
REQ-028 Reset asserted mid-turn (MOVE/JUMP/CHECK) abandons the turn with no partial update surviving.
REQ-029 First start accepted on the first rising edge after rstn deasserts.

Configuration
REQ-030 Macro SNL_BOUNCE_BACK_EN selects overshoot rule.
REQ-031 Defined: overshoot pos <= 2*(BOARD_SIZE-1) - tentative; undefined: overshoot leaves pos unchanged (exact finish required).

Structure
REQ-032 Package snl_pkg holds the state enum, default BOARD_SIZE, and default snake/ladder table.
REQ-033 Default table (64 squares): ladders 3->20, 11->28, 40->58; snakes 27->5, 45->25, 62->34.
REQ-034 Sub-module snl_jump_map: combinational square -> destination lookup, parameterised by BOARD_SIZE.

Verification
REQ-035 P0 rolls 3 from 0 -> pos 3 after MOVE, 20 after JUMP; cur_player becomes 1.
REQ-036 P0 rolls 6 from 0 -> pos 6, cur_player stays 0, dice_ready high next turn.
REQ-037 P0 at 60 rolls 5: without macro stays 60; with SNL_BOUNCE_BACK_EN ends 61.
REQ-038 P1 at 57 rolls 6 -> 63, state WIN, winner 1; further dice ignored; start -> all pos 0.
REQ-039 dice=0 and dice=7 in WAIT_ROLL -> dice_err pulse each, positions unchanged.
REQ-040 rstn pulsed low during JUMP -> state 0, all pos 0 without a clock edge.
